// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch PC, imem req/gnt/rvalid handshake,
// small fetch FIFO and the IF/ID output register with redirect/flush/stall.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        take_bj_sig_i,
    input  logic [31:0] pc_bj_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;

    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pc_q, pc_d;
    logic          valid_q, valid_d;

    logic          req;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    logic          unused_bj_lsb;
    assign unused_bj_lsb = ^pc_bj_i[1:0];

    // Responses are only honoured while a request is in flight, so a late
    // beat from before a reset can never land in the FIFO.
    always_comb begin
        req        = !outstanding_q && (count_q < DEPTH_C) && !take_bj_sig_i;
        grant      = req && imem_gnt_i;
        rsp        = imem_rvalid_i && outstanding_q;
        fifo_empty = (count_q == '0);
        push       = rsp && !discard_q && !take_bj_sig_i;
        pop        = !take_bj_sig_i && !flush_i && !stall_i && !fifo_empty;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (rsp) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
        end
        if (grant) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end
        if (take_bj_sig_i) begin
            fetch_pc_d = {pc_bj_i[31:2], 2'b00};
            discard_d  = (outstanding_q && !rsp) || grant;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (take_bj_sig_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (take_bj_sig_i || flush_i) begin
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (!fifo_empty) begin
            instr_d = fifo_instr_q[rd_ptr_q];
            pc_d    = fifo_pc_q[rd_ptr_q];
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            instr_q       <= NOP;
            pc_q          <= 32'h0;
            valid_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = fetch_pc_q;
    assign instr_o     = instr_q;
    assign pc_o        = pc_q;
    assign valid_o     = valid_q;

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end that feeds the ID stage's IF/ID inputs (instr_o, pc_o, valid_o).
- Owns the fetch PC and drives a request/grant/response handshake to an external variable-latency instruction memory.
- Buffers returned words in a small FIFO and applies EX-stage branch/jump redirects, flush and stall.
- Replaces the fixed-latency fetch path so instruction memory may insert wait states.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
DEPTH, 2, fetch-buffer entries (power of two, >=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
stall_i  in  1  hold the IF/ID output register
flush_i  in  1  squash the IF/ID output register
take_bj_sig_i  in  1  EX-stage branch/jump taken
pc_bj_i  in  32  redirect target
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (word aligned)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  32  response instruction word
instr_o  out  32  instruction to ID
pc_o  out  32  PC of instr_o
valid_o  out  1  instr_o/pc_o valid

Behaviour:
- Reset values (async, rst_i=1):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - valid_o=0; instr_o=32'h0000_0013 (NOP); pc_o=0.
- Request rule:
  - imem_req_o = !outstanding && (count < DEPTH) && !take_bj_sig_i.
  - imem_addr_o = fetch_pc.
  - Max one outstanding request.
- Grant:
  - req && gnt sets outstanding=1, records req_pc=fetch_pc, and advances fetch_pc += 4 (32-bit wrap at 0xFFFF_FFFC -> 0).
  - An ungranted request may be withdrawn only by a redirect.
- Response:
  - Memory must not assert imem_rvalid_i before the cycle after gnt.
  - On rvalid: outstanding<=0.
  - If discard=1: drop the data and clear discard. Otherwise push {req_pc, imem_rdata_i} into the FIFO.
  - The FIFO never overflows, because a request is issued only when count<DEPTH and only responses push.
- Output register (priority: reset > take_bj_sig_i > flush_i > stall_i > normal):
  - take_bj_sig_i: valid_o<=0; FIFO cleared; fetch_pc<={pc_bj_i[31:2],2'b00}. If outstanding, or being granted this cycle, set discard=1. A same-cycle rvalid is dropped.
  - flush_i (no redirect): valid_o<=0; no pop; FIFO and fetch_pc unchanged.
  - stall_i: instr_o/pc_o/valid_o hold; no pop.
  - Normal, FIFO non-empty: pop head into instr_o/pc_o, valid_o<=1.
  - Normal, FIFO empty: valid_o<=0; instr_o/pc_o hold.
- Same-cycle push and pop is allowed; count is unchanged.
- Count range is 0..DEPTH; the pointers wrap modulo DEPTH.
- No FIFO bypass. Latency gnt(t) -> rvalid(t+1) -> valid_o=1 at t+3.
- Zero-wait memory (gnt=1, rvalid the next cycle) sustains one instruction per 2 cycles with DEPTH>=2.
- Reset mid-transaction returns to the reset state. Any in-flight memory response after reset release with outstanding=0 is ignored.

Test Plan:
- Reset, RESET_PC=0; memory grants immediately and returns word = addr|0x13 one cycle later -> imem_addr_o sequence 0,4,8; valid_o pulses with pc_o=0,4,8 and instr_o=0x13,0x17,0x1B in order, first valid_o 3 cycles after the first gnt.
- Hold stall_i=1 for 10 cycles -> FIFO fills to DEPTH, imem_req_o drops to 0, outputs frozen. Release -> buffered PCs emerge in order with no loss or duplication.
- Redirect to 0x100 while a request at 0x8 is outstanding -> 0x8 response dropped; next valid_o has pc_o=0x100; no stale PC appears after take_bj_sig_i.
- Redirect with pc_bj_i=0x203 while the request is ungranted (gnt held 0) -> request withdrawn; next imem_addr_o=0x200.
- flush_i for one cycle with 2 entries buffered -> valid_o=0 that cycle; the following cycles deliver both entries unchanged.
- Assert rst_i mid-stream with a response pending -> valid_o=0 and instr_o=0x13 immediately. After release, imem_addr_o=RESET_PC and the late rvalid is ignored.
